top_prj_gameplay: RTL and testbench

//  Top-level gameplay block: generates 1024x768 VGA timing (1344x806 total) from one clock and renders
//  a background plus a key-controlled player square. Position updates once per frame from key[3:0].

---
 rtl/vga_pkg.sv | 54 +++++
 rtl/vga_timing.sv | 53 +++++
 rtl/top_prj_gameplay.sv | 139 +++++++++++++
 tb/tb_top_prj_gameplay.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA geometry, colour constants and position helpers for the gameplay block.
package vga_pkg;

  // Counter and position widths
  localparam int CNT_W = 11;
  localparam int POS_W = 12;

  // 1024x768 frame in a 1344x806 total raster
  localparam int H_VIS  = 1024;
  localparam int H_FP   = 24;
  localparam int H_SYNC = 136;
  localparam int H_BP   = 160;

  localparam int V_VIS  = 768;
  localparam int V_FP   = 3;
  localparam int V_SYNC = 6;
  localparam int V_BP   = 29;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_BLANK  = rgb_t'(12'h000);
  localparam rgb_t COL_PLAYER = rgb_t'(12'hF80);
  localparam rgb_t COL_BORDER = rgb_t'(12'hFFF);
  localparam rgb_t COL_BG     = rgb_t'(12'h114);

  // What a pixel is showing, highest priority first
  typedef enum logic [1:0] {
    PIX_BLANK,
    PIX_PLAYER,
    PIX_BORDER,
    PIX_BG
  } pix_class_e;

  typedef logic signed [POS_W-1:0] pos_t;

  // Movement along one axis; both directions pressed together cancel out
  function automatic pos_t axis_delta(input logic inc, input logic dec, input pos_t step);
    if (inc && !dec) return step;
    else if (dec && !inc) return -step;
    else return '0;
  endfunction

  // Keep a coordinate inside 0..hi; negative results come from moving past the left/top edge
  function automatic pos_t clamp_pos(input pos_t p, input pos_t hi);
    if (p[POS_W-1]) return '0;
    else if (p > hi) return hi;
    else return p;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus combinational sync and blank decode.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS_PX  = H_VIS,
  parameter int H_FP_PX   = H_FP,
  parameter int H_SYNC_PX = H_SYNC,
  parameter int H_BP_PX   = H_BP,
  parameter int V_VIS_LN  = V_VIS,
  parameter int V_FP_LN   = V_FP,
  parameter int V_SYNC_LN = V_SYNC,
  parameter int V_BP_LN   = V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             blank
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS_PX + H_FP_PX + H_SYNC_PX + H_BP_PX - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS_LN + V_FP_LN + V_SYNC_LN + V_BP_LN - 1);
  localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS_PX);
  localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS_LN);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS_PX + H_FP_PX);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS_PX + H_FP_PX + H_SYNC_PX);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS_LN + V_FP_LN);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS_LN + V_FP_LN + V_SYNC_LN);

  // Horizontal counter wraps at end of line and advances the vertical counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      if (vcount == V_LAST) vcount <= '0;
      else vcount <= vcount + CNT_W'(1);
    end else begin
      hcount <= hcount + CNT_W'(1);
    end
  end

  // Active-low syncs and blank decoded straight from the counters
  always_comb begin
    hsync = !((hcount >= HS_START) && (hcount < HS_END));
    vsync = !((vcount >= VS_START) && (vcount < VS_END));
    blank = (hcount >= H_VIS_C) || (vcount >= V_VIS_C);
  end

endmodule

// File: rtl/top_prj_gameplay.sv
// Gameplay top: VGA raster, key-driven player square, registered RGB/hs/vs outputs.
module top_prj_gameplay
  import vga_pkg::*;
#(
  parameter int PLAYER_SIZE = 64,
  parameter int STEP        = 4,
  parameter int START_X     = 480,
  parameter int START_Y     = 352,
  parameter int H_VIS_PX    = H_VIS,
  parameter int H_FP_PX     = H_FP,
  parameter int H_SYNC_PX   = H_SYNC,
  parameter int H_BP_PX     = H_BP,
  parameter int V_VIS_LN    = V_VIS,
  parameter int V_FP_LN     = V_FP,
  parameter int V_SYNC_LN   = V_SYNC,
  parameter int V_BP_LN     = V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic       vs,
  output logic       hs,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
);

  localparam pos_t SIZE_S  = POS_W'(PLAYER_SIZE);
  localparam pos_t STEP_S  = POS_W'(STEP);
  localparam pos_t MAX_X   = POS_W'(H_VIS_PX - PLAYER_SIZE);
  localparam pos_t MAX_Y   = POS_W'(V_VIS_LN - PLAYER_SIZE);
  localparam pos_t START_XS = POS_W'(START_X);
  localparam pos_t START_YS = POS_W'(START_Y);
  localparam logic [CNT_W-1:0] UPD_LINE = CNT_W'(V_VIS_LN);
  localparam logic [CNT_W-1:0] H_EDGE   = CNT_W'(H_VIS_PX - 1);
  localparam logic [CNT_W-1:0] V_EDGE   = CNT_W'(V_VIS_LN - 1);

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hsync;
  logic             vsync;
  logic             blank;

  pos_t       pos_x;
  pos_t       pos_y;
  pos_t       next_x;
  pos_t       next_y;
  logic       update_pt;
  pos_t       h_s;
  pos_t       v_s;
  logic       in_sq;
  logic       on_border;
  pix_class_e pix_class;
  rgb_t       pix_col;

  vga_timing #(
    .H_VIS_PX  (H_VIS_PX),
    .H_FP_PX   (H_FP_PX),
    .H_SYNC_PX (H_SYNC_PX),
    .H_BP_PX   (H_BP_PX),
    .V_VIS_LN  (V_VIS_LN),
    .V_FP_LN   (V_FP_LN),
    .V_SYNC_LN (V_SYNC_LN),
    .V_BP_LN   (V_BP_LN)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .hcount (hcount),
    .vcount (vcount),
    .hsync  (hsync),
    .vsync  (vsync),
    .blank  (blank)
  );

  // Candidate next position: signed step then clamp, so the square never wraps
  always_comb begin
    update_pt = (hcount == '0) && (vcount == UPD_LINE);
    next_x    = clamp_pos(pos_x + axis_delta(key[3], key[2], STEP_S), MAX_X);
    next_y    = clamp_pos(pos_y + axis_delta(key[1], key[0], STEP_S), MAX_Y);
  end

  // Position moves only at the start of vertical blank so a frame is never drawn half-moved
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_x <= START_XS;
      pos_y <= START_YS;
    end else if (update_pt) begin
      pos_x <= next_x;
      pos_y <= next_y;
    end
  end

  // Geometry tests for the current raster position
  always_comb begin
    h_s       = pos_t'({1'b0, hcount});
    v_s       = pos_t'({1'b0, vcount});
    in_sq     = (h_s >= pos_x) && (h_s < pos_x + SIZE_S) &&
                (v_s >= pos_y) && (v_s < pos_y + SIZE_S);
    on_border = (hcount == '0) || (hcount == H_EDGE) ||
                (vcount == '0) || (vcount == V_EDGE);
  end

  // Pixel classification in priority order: blank, player, border, background
  always_comb begin
    pix_class = PIX_BG;
    if (blank) pix_class = PIX_BLANK;
    else if (in_sq) pix_class = PIX_PLAYER;
    else if (on_border) pix_class = PIX_BORDER;
  end

  // Class to colour lookup
  always_comb begin
    pix_col = COL_BG;
    case (pix_class)
      PIX_BLANK:  pix_col = COL_BLANK;
      PIX_PLAYER: pix_col = COL_PLAYER;
      PIX_BORDER: pix_col = COL_BORDER;
      default:    pix_col = COL_BG;
    endcase
  end

  // Single output register stage keeps colour and syncs aligned
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs <= 1'b1;
      vs <= 1'b1;
      r  <= '0;
      g  <= '0;
      b  <= '0;
    end else begin
      hs <= hsync;
      vs <= vsync;
      r  <= pix_col.r;
      g  <= pix_col.g;
      b  <= pix_col.b;
    end
  end

endmodule

// File: tb/tb_top_prj_gameplay.sv
// Directed bench for top_prj_gameplay on a shrunken raster so many frames fit in a short run.
module tb_top_prj_gameplay;

  localparam int PSIZE = 8;
  localparam int STEP  = 4;
  localparam int SX    = 12;
  localparam int SY    = 6;
  localparam int HV = 32, HF = 2, HSY = 6, HB = 8, HT = 48;
  localparam int VV = 24, VF = 2, VSY = 2, VB = 4, VT = 32;
  localparam int FRAME = HT * VT;

  logic       clk;
  logic       rst;
  logic [3:0] key;
  logic       vs;
  logic       hs;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;

  int vectors = 0;
  int miscompares = 0;

  logic run = 1'b0;
  int   th = 0, tv = 0, frames = 0, blank_err = 0, sync_err = 0;
  logic exp_hs, exp_vs;
  logic [11:0] fb [VV][HV];

  top_prj_gameplay #(
    .PLAYER_SIZE (PSIZE), .STEP (STEP), .START_X (SX), .START_Y (SY),
    .H_VIS_PX (HV), .H_FP_PX (HF), .H_SYNC_PX (HSY), .H_BP_PX (HB),
    .V_VIS_LN (VV), .V_FP_LN (VF), .V_SYNC_LN (VSY), .V_BP_LN (VB)
  ) dut (
    .clk (clk), .rst (rst), .key (key), .vs (vs), .hs (hs), .r (r), .g (g), .b (b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame capture: tracks which raster pixel is on the outputs and records it
  always @(negedge clk) begin
    if (!run) begin
      th = 0;
      tv = 0;
    end else begin
      if (th < HV && tv < VV) fb[tv][th] = {r, g, b};
      else if ({r, g, b} !== 12'h000) blank_err++;
      exp_hs = !((th >= HV + HF) && (th < HV + HF + HSY));
      exp_vs = !((tv >= VV + VF) && (tv < VV + VF + VSY));
      if (hs !== exp_hs || vs !== exp_vs) sync_err++;
      if (th == HT - 1 && tv == VV - 1) frames++;
      if (th == HT - 1) begin
        th = 0;
        tv = (tv == VT - 1) ? 0 : tv + 1;
      end else begin
        th++;
      end
    end
  end

  function automatic logic [11:0] exp_pix(input int h, input int v, input int ex, input int ey);
    if (h >= ex && h < ex + PSIZE && v >= ey && v < ey + PSIZE) return 12'hF80;
    if (h == 0 || h == HV - 1 || v == 0 || v == VV - 1) return 12'hFFF;
    return 12'h114;
  endfunction

  task automatic wait_frames(input int n);
    int target = frames + n;
    int cnt = 0;
    while (frames < target && cnt < (n + 1) * FRAME) begin
      @(negedge clk); #1;
      cnt++;
    end
    if (frames < target) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: saw %0d frames after %0d clks, required %0d", frames, cnt, target);
    end
  endtask

  task automatic wait_line(input int line);
    int cnt = 0;
    while (tv != line && cnt < 2 * FRAME) begin
      @(negedge clk); #1;
      cnt++;
    end
    if (tv != line) begin
      vectors++;
      miscompares++;
      $display("FAIL line_timeout: at line %0d, required %0d", tv, line);
    end
  endtask

  task automatic check_frame(input string name, input int ex, input int ey);
    int fx = -1, fy = -1, errs = 0;
    for (int v = 0; v < VV; v++)
      for (int h = 0; h < HV; h++) begin
        if (fx < 0 && fb[v][h] === 12'hF80) begin
          fx = h;
          fy = v;
        end
        if (fb[v][h] !== exp_pix(h, v, ex, ey)) errs++;
      end
    vectors++;
    if (fx !== ex || fy !== ey) begin
      miscompares++;
      $display("FAIL %s_pos: square at (%0d,%0d), required (%0d,%0d)", name, fx, fy, ex, ey);
    end
    vectors++;
    if (errs !== 0) begin
      miscompares++;
      $display("FAIL %s_image: %0d wrong pixels, required 0", name, errs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key = 4'b0000;
    run = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (hs !== 1'b1) begin miscompares++; $display("FAIL reset_hs: got %b, required 1", hs); end
    vectors++;
    if (vs !== 1'b1) begin miscompares++; $display("FAIL reset_vs: got %b, required 1", vs); end
    vectors++;
    if ({r, g, b} !== 12'h000) begin miscompares++; $display("FAIL reset_rgb: got %h, required 000", {r, g, b}); end
    rst = 1'b1;
    @(posedge clk);
    run = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({r, g, b} !== 12'hFFF) begin miscompares++; $display("FAIL first_pixel: got %h, required fff", {r, g, b}); end
  endtask

  task automatic test_sync();
    int n = 0, low = 0, per = 0;
    while (hs !== 1'b0 && n < 2 * HT) begin @(negedge clk); #1; n++; end
    while (hs === 1'b0 && low < 2 * HT) begin @(negedge clk); #1; low++; end
    vectors++;
    if (low !== HSY) begin miscompares++; $display("FAIL hs_width: got %0d clks, required %0d", low, HSY); end
    n = 0;
    while (vs !== 1'b0 && n < 2 * FRAME) begin @(negedge clk); #1; n++; end
    low = 0;
    while (vs === 1'b0 && per < 2 * FRAME) begin @(negedge clk); #1; per++; low++; end
    while (vs !== 1'b0 && per < 2 * FRAME) begin @(negedge clk); #1; per++; end
    vectors++;
    if (low !== VSY * HT) begin miscompares++; $display("FAIL vs_width: got %0d clks, required %0d", low, VSY * HT); end
    vectors++;
    if (per !== FRAME) begin miscompares++; $display("FAIL vs_period: got %0d clks, required %0d", per, FRAME); end
    wait_frames(1);
  endtask

  task automatic test_move(input string name, input logic [3:0] k, input int n, input int ex, input int ey);
    key = k;
    wait_frames(n);
    check_frame(name, ex, ey);
  endtask

  task automatic test_midframe_key();
    wait_line(5);
    key = 4'b1000;
    wait_line(VV - 2);
    key = 4'b0000;
    wait_frames(2);
    check_frame("midframe_key", SX, SY);
  endtask

  task automatic test_pixels();
    int          ph [8] = '{0, 12, 19, 20, 12, 2, 31, 5};
    int          pv [8] = '{0, 6, 13, 6, 14, 2, 10, 23};
    logic [11:0] pe [8] = '{12'hFFF, 12'hF80, 12'hF80, 12'h114, 12'h114, 12'h114, 12'hFFF, 12'hFFF};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (fb[pv[i]][ph[i]] !== pe[i]) begin
        miscompares++;
        $display("FAIL pixel_%0d_%0d: got %h, required %h", ph[i], pv[i], fb[pv[i]][ph[i]], pe[i]);
      end
    end
    vectors++;
    if (blank_err !== 0) begin miscompares++; $display("FAIL blank_pixels: %0d nonzero, required 0", blank_err); end
  endtask

  task automatic test_midframe_reset();
    wait_line(10);
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if ({hs, vs, r, g, b} !== 14'b11_0000_0000_0000) begin
      miscompares++;
      $display("FAIL midreset_out: got hs=%b vs=%b rgb=%h, required 1 1 000", hs, vs, {r, g, b});
    end
    rst = 1'b1;
    @(posedge clk);
    run = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({r, g, b} !== 12'hFFF) begin miscompares++; $display("FAIL midreset_first: got %h, required fff", {r, g, b}); end
    key = 4'b0000;
    wait_frames(1);
    check_frame("midreset_frame", SX, SY);
  endtask

  task automatic test_sync_alignment();
    vectors++;
    if (sync_err !== 0) begin miscompares++; $display("FAIL sync_align: %0d bad samples, required 0", sync_err); end
    vectors++;
    if (blank_err !== 0) begin miscompares++; $display("FAIL blank_final: %0d nonzero, required 0", blank_err); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_move("left_down", 4'b0110, 2, 4, 14);
    test_move("right_up", 4'b1001, 2, SX, SY);
    test_move("cancel", 4'b1111, 3, SX, SY);
    test_midframe_key();
    test_pixels();
    test_move("clamp_left", 4'b0100, 5, 0, SY);
    test_move("clamp_down", 4'b0010, 4, 0, VV - PSIZE);
    test_move("clamp_right", 4'b1000, 7, HV - PSIZE, VV - PSIZE);
    test_midframe_reset();
    test_sync_alignment();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
